// File: rtl/rsa_enc_pkg.sv
// -----------------------------------------------------------------------------
// rsa_enc_pkg
// Shared definitions for the RSA encryption stage:
//   - WIDTH_DEFAULT : default base width (data/modulus are 4*WIDTH bits,
//                     exponent is WIDTH bits)
//   - ST_*          : 4-bit state encodings, and state_t built from them
//   - mult_cycles() : clock cycles taken by one modular multiply
// -----------------------------------------------------------------------------
package rsa_enc_pkg;

    localparam int WIDTH_DEFAULT = 512;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LOAD   = 4'd1;
    localparam logic [3:0] ST_SQUARE = 4'd2;
    localparam logic [3:0] ST_MULT   = 4'd3;
    localparam logic [3:0] ST_DONE   = 4'd4;
    localparam logic [3:0] ST_ERR    = 4'd5;

    typedef enum logic [3:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_SQUARE = ST_SQUARE,
        S_MULT   = ST_MULT,
        S_DONE   = ST_DONE,
        S_ERR    = ST_ERR
    } state_t;

    // One start cycle, one iteration per multiplier bit, one done cycle.
    function automatic int mult_cycles(input int width);
        return 4 * width + 2;
    endfunction

endpackage

// File: rtl/rsa_encryption_mod_mult.sv
// -----------------------------------------------------------------------------
// mod_mult_serial
// Bit-serial interleaved modular multiplier: result = a*b mod n.
// The multiplier b is scanned MSB first; each step does acc = 2*acc + b_j*a
// followed by up to two conditional subtractions of n. Operands must be < n.
// Latency is mult_cycles(WIDTH): start cycle, 4*WIDTH iterations, done cycle.
// Ports:
//   aclk, aresetn : clock, asynchronous active-low reset
//   a, b, n       : operands and modulus, sampled when start is high
//   start         : one-cycle pulse launching a multiply
//   result        : a*b mod n, valid while done is high and held afterwards
//   done          : one-cycle pulse when result is ready
// -----------------------------------------------------------------------------
module mod_mult_serial
    import rsa_enc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [4*WIDTH-1:0]   a,
    input  logic [4*WIDTH-1:0]   b,
    input  logic [4*WIDTH-1:0]   n,
    input  logic                 start,
    output logic [4*WIDTH-1:0]   result,
    output logic                 done
);

    localparam int DW    = 4 * WIDTH;
    localparam int AW    = DW + 2;       // 2*acc + a < 3n needs two guard bits
    localparam int ITERS = mult_cycles(WIDTH) - 2;
    localparam int CW    = $clog2(ITERS);

    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] n_q;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          run;

    logic [AW-1:0] n_ext;
    logic [AW-1:0] acc_dbl;
    logic [AW-1:0] acc_s1;
    logic [AW-1:0] acc_s2;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        n_ext   = {2'b00, n_q};
        acc_dbl = (acc << 1) + (b_q[DW-1] ? {2'b00, a_q} : '0);
        acc_s1  = (acc_dbl >= n_ext) ? acc_dbl - n_ext : acc_dbl;
        acc_s2  = (acc_s1 >= n_ext) ? acc_s1 - n_ext : acc_s1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            a_q  <= '0;
            b_q  <= '0;
            n_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q <= a;
                b_q <= b;
                n_q <= n;
                acc <= '0;
                cnt <= CW'(ITERS - 1);
                run <= 1'b1;
            end else if (run) begin
                acc <= acc_s2;
                b_q <= {b_q[DW-2:0], 1'b0};
                if (cnt == '0) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign result = acc[DW-1:0];

endmodule

// File: rtl/rsa_encryption.sv
// -----------------------------------------------------------------------------
// rsa_encryption
// RSA public-key encryption: c = m^e mod n by left-to-right square-and-multiply
// over mod_mult_serial. Ciphertext drives the decryption block's data inputs.
// Ports:
//   aclk, aresetn     : clock, asynchronous active-low reset
//   In_publicKey_exp  : public exponent e (WIDTH bits)
//   In_publicKey_mod  : public modulus n (4*WIDTH bits)
//   In_key_valid      : key valid level, latched every IDLE cycle it is high
//   In_Plain_word     : plaintext m (4*WIDTH bits)
//   In_Plain_valid    : plaintext valid
//   Plain_ready       : block is idle with a usable key
//   Out_Cipher_word   : ciphertext, held until the next result
//   Out_Cipher_valid  : one-cycle pulse with a new ciphertext
//   Out_error         : one-cycle pulse when a plaintext m >= n is rejected
//   busy              : high in every state except IDLE
// Configuration macro: RSA_ENC_RANGE_CHECK_EN builds the m >= n check;
// without it Out_error is tied low.
// -----------------------------------------------------------------------------
module rsa_encryption
    import rsa_enc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [WIDTH-1:0]     In_publicKey_exp,
    input  logic [4*WIDTH-1:0]   In_publicKey_mod,
    input  logic                 In_key_valid,
    input  logic [4*WIDTH-1:0]   In_Plain_word,
    input  logic                 In_Plain_valid,
    output logic                 Plain_ready,
    output logic [4*WIDTH-1:0]   Out_Cipher_word,
    output logic                 Out_Cipher_valid,
    output logic                 Out_error,
    output logic                 busy
);

    localparam int DW    = 4 * WIDTH;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;

    // Published key; op_* is the copy frozen at accept so a key update in
    // the accept cycle only affects the next plaintext.
    logic [WIDTH-1:0] key_e;
    logic [DW-1:0]    key_n;
    logic             key_ok;
    logic [WIDTH-1:0] op_e;
    logic [DW-1:0]    op_n;

    logic [DW-1:0]    m_q;
    logic [DW-1:0]    r_q;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_dec;
    logic [IDX_W-1:0] top_idx;

    logic             mul_start;
    logic [DW-1:0]    mul_b;
    logic [DW-1:0]    mul_result;
    logic             mul_done;

    logic [DW-1:0]    cipher_q;
    logic             cvalid_q;
    logic             accept;

    assign Plain_ready      = (state == S_IDLE) && key_ok;
    assign accept           = In_Plain_valid && Plain_ready;
    assign busy             = (state != S_IDLE);
    assign Out_Cipher_word  = cipher_q;
    assign Out_Cipher_valid = cvalid_q;
    assign idx_dec          = idx - 1'b1;
    assign mul_b            = (state == S_MULT) ? m_q : r_q;

    // Index of the most significant set bit of the frozen exponent.
    always_comb begin
        top_idx = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (op_e[j]) top_idx = IDX_W'(j);
        end
    end

`ifdef RSA_ENC_RANGE_CHECK_EN
    logic err_q;
    logic m_ge_n;
    assign m_ge_n    = (m_q >= op_n);
    assign Out_error = err_q;
`else
    assign Out_error = 1'b0;
`endif

    mod_mult_serial #(
        .WIDTH (WIDTH)
    ) u_mod_mult (
        .aclk    (aclk),
        .aresetn (aresetn),
        .a       (r_q),
        .b       (mul_b),
        .n       (op_n),
        .start   (mul_start),
        .result  (mul_result),
        .done    (mul_done)
    );

    // The valid/error pulses are registered on entry to DONE/ERR, so they are
    // high exactly during those states and the ciphertext is already stable.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            key_e     <= '0;
            key_n     <= '0;
            key_ok    <= 1'b0;
            op_e      <= '0;
            op_n      <= '0;
            m_q       <= '0;
            r_q       <= '0;
            idx       <= '0;
            mul_start <= 1'b0;
            cipher_q  <= '0;
            cvalid_q  <= 1'b0;
`ifdef RSA_ENC_RANGE_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            mul_start <= 1'b0;
            cvalid_q  <= 1'b0;
`ifdef RSA_ENC_RANGE_CHECK_EN
            err_q     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (In_key_valid) begin
                        key_e  <= In_publicKey_exp;
                        key_n  <= In_publicKey_mod;
                        key_ok <= (In_publicKey_mod >= DW'(3)) &&
                                  (In_publicKey_exp != '0);
                    end
                    if (accept) begin
                        m_q   <= In_Plain_word;
                        op_e  <= key_e;
                        op_n  <= key_n;
                        state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    r_q <= m_q;
                    idx <= top_idx;
`ifdef RSA_ENC_RANGE_CHECK_EN
                    if (m_ge_n) begin
                        err_q <= 1'b1;
                        state <= S_ERR;
                    end else
`endif
                    if (top_idx == '0) begin
                        cipher_q <= m_q;
                        cvalid_q <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        mul_start <= 1'b1;
                        state     <= S_SQUARE;
                    end
                end

                S_SQUARE: begin
                    if (mul_done) begin
                        r_q <= mul_result;
                        idx <= idx_dec;
                        if (op_e[idx_dec]) begin
                            mul_start <= 1'b1;
                            state     <= S_MULT;
                        end else if (idx_dec == '0) begin
                            cipher_q <= mul_result;
                            cvalid_q <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            mul_start <= 1'b1;
                            state     <= S_SQUARE;
                        end
                    end
                end

                S_MULT: begin
                    if (mul_done) begin
                        r_q <= mul_result;
                        if (idx == '0) begin
                            cipher_q <= mul_result;
                            cvalid_q <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            mul_start <= 1'b1;
                            state     <= S_SQUARE;
                        end
                    end
                end

                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_encryption.sv
// -----------------------------------------------------------------------------
// tb_rsa_encryption
// Self-checking bench for rsa_encryption. Two instances: WIDTH=8 for the
// directed key/latency/reset cases and WIDTH=32 for the 65537 exponent case.
// Expected ciphertexts come from a right-to-left modular exponentiation model;
// expected latency comes from k = t + popcount(e) - 1 multiplies.
// -----------------------------------------------------------------------------
module tb_rsa_encryption;

    logic         clk;
    logic         aresetn;
    logic [31:0]  key_e;
    logic [127:0] key_n;
    logic [127:0] plain;
    logic         kv8, kv32, pv8, pv32;

    logic         rdy8, rdy32, cv8, cv32, err8, err32, busy8, busy32;
    logic [31:0]  c8;
    logic [127:0] c32;

    int checks = 0;
    int errors = 0;

    rsa_encryption #(.WIDTH(8)) dut8 (
        .aclk             (clk),
        .aresetn          (aresetn),
        .In_publicKey_exp (key_e[7:0]),
        .In_publicKey_mod (key_n[31:0]),
        .In_key_valid     (kv8),
        .In_Plain_word    (plain[31:0]),
        .In_Plain_valid   (pv8),
        .Plain_ready      (rdy8),
        .Out_Cipher_word  (c8),
        .Out_Cipher_valid (cv8),
        .Out_error        (err8),
        .busy             (busy8)
    );

    rsa_encryption #(.WIDTH(32)) dut32 (
        .aclk             (clk),
        .aresetn          (aresetn),
        .In_publicKey_exp (key_e),
        .In_publicKey_mod (key_n),
        .In_key_valid     (kv32),
        .In_Plain_word    (plain),
        .In_Plain_valid   (pv32),
        .Plain_ready      (rdy32),
        .Out_Cipher_word  (c32),
        .Out_Cipher_valid (cv32),
        .Out_error        (err32),
        .busy             (busy32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [127:0] modexp(input logic [127:0] m,
                                            input logic [127:0] e,
                                            input logic [127:0] n);
        logic [127:0] r, b, x;
        r = 128'd1;
        b = m % n;
        x = e;
        while (x != 0) begin
            if (x[0]) r = (r * b) % n;
            b = (b * b) % n;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic int latency(input logic [31:0] e, input int w);
        int t, pc;
        t = 0;
        pc = 0;
        for (int j = 0; j < 32; j++) begin
            if (e[j]) begin
                t = j;
                pc++;
            end
        end
        return 2 + (t + pc - 1) * (4 * w + 2);
    endfunction

    // ---------------- access helpers ----------------
    function automatic logic rdy(input int sel);
        return (sel != 0) ? rdy32 : rdy8;
    endfunction
    function automatic logic cval(input int sel);
        return (sel != 0) ? cv32 : cv8;
    endfunction
    function automatic logic errv(input int sel);
        return (sel != 0) ? err32 : err8;
    endfunction
    function automatic logic bsy(input int sel);
        return (sel != 0) ? busy32 : busy8;
    endfunction
    function automatic logic [127:0] word(input int sel);
        return (sel != 0) ? c32 : {96'b0, c8};
    endfunction

    task automatic set_kv(input int sel, input logic v);
        if (sel != 0) kv32 = v; else kv8 = v;
    endtask
    task automatic set_pv(input int sel, input logic v);
        if (sel != 0) pv32 = v; else pv8 = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_key(input int sel, input logic [31:0] e,
                            input logic [127:0] n);
        key_e = e;
        key_n = n;
        set_kv(sel, 1'b1);
        tick();
        set_kv(sel, 1'b0);
    endtask

    // Accept m, optionally presenting a new key in the same cycle, then wait
    // (bounded) for the ciphertext and check value, latency and hold.
    task automatic encrypt(input string tag, input int sel, input int w,
                           input logic [127:0] m, input logic [31:0] e,
                           input logic [127:0] n, input bit upd,
                           input logic [31:0] ue, input logic [127:0] un);
        logic [127:0] expc;
        int lat, cyc, errs_seen;
        bit got;
        expc = modexp(m, {96'b0, e}, n);
        lat  = latency(e, w);
        check({tag, "/ready_before"}, rdy(sel), 1'b1);
        plain = m;
        set_pv(sel, 1'b1);
        if (upd) begin
            key_e = ue;
            key_n = un;
            set_kv(sel, 1'b1);
        end
        tick();
        set_pv(sel, 1'b0);
        set_kv(sel, 1'b0);
        cyc = 1;
        check({tag, "/ready_drop"}, rdy(sel), 1'b0);
        check({tag, "/busy"}, bsy(sel), 1'b1);
        got = 1'b0;
        errs_seen = 0;
        while (!got && cyc < lat + 8) begin
            tick();
            cyc++;
            if (errv(sel)) errs_seen++;
            if (cval(sel)) got = 1'b1;
        end
        check({tag, "/valid_seen"}, got, 1'b1);
        check({tag, "/latency"}, cyc, lat);
        check({tag, "/cipher"}, word(sel), expc);
        check({tag, "/no_error"}, errs_seen, 0);
        tick();
        check({tag, "/valid_pulse"}, cval(sel), 1'b0);
        check({tag, "/hold"}, word(sel), expc);
        check({tag, "/ready_back"}, rdy(sel), 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc, pulses, ready_hi, errs_seen;
        logic [31:0]  re;
        logic [127:0] rn, rm;

        aresetn = 1'b0;
        key_e = '0;
        key_n = '0;
        plain = '0;
        kv8 = 1'b0; kv32 = 1'b0; pv8 = 1'b0; pv32 = 1'b0;
        repeat (3) tick();

        check("rst/ready", rdy8, 1'b0);
        check("rst/cipher", word(0), 128'd0);
        check("rst/valid", cv8, 1'b0);
        check("rst/error", err8, 1'b0);
        check("rst/busy", busy8, 1'b0);

        aresetn = 1'b1;
        tick();

        // Key validation: valid key enables, n<3 or e==0 disables.
        load_key(0, 32'd17, 128'd3233);
        check("key/valid_ok", rdy8, 1'b1);
        load_key(0, 32'd0, 128'd3233);
        check("key/e0_rejected", rdy8, 1'b0);
        load_key(0, 32'd17, 128'd3233);
        check("key/reload_ok", rdy8, 1'b1);
        load_key(0, 32'd17, 128'd2);
        tick();
        check("key/n2_rejected", rdy8, 1'b0);
        load_key(0, 32'd17, 128'd3233);
        check("key/final_ok", rdy8, 1'b1);

        // Textbook vector and the trivial plaintexts.
        encrypt("m65", 0, 8, 128'd65, 32'd17, 128'd3233, 1'b0, '0, '0);
        check("m65/textbook", word(0), 128'd2790);
        encrypt("m0", 0, 8, 128'd0, 32'd17, 128'd3233, 1'b0, '0, '0);
        encrypt("m1", 0, 8, 128'd1, 32'd17, 128'd3233, 1'b0, '0, '0);

        // Key update in the accept cycle: old e=17 is used, e=1 afterwards.
        encrypt("swap_old", 0, 8, 128'd123, 32'd17, 128'd3233,
                1'b1, 32'd1, 128'd3233);
        encrypt("e1", 0, 8, 128'd123, 32'd1, 128'd3233, 1'b0, '0, '0);

        // Random keys and plaintexts.
        for (int i = 0; i < 4; i++) begin
            re = $urandom_range(255, 1);
            rn = {96'b0, $urandom_range(32'hFFFF_FFFF, 3)};
            rm = {96'b0, $urandom} % rn;
            load_key(0, re, rn);
            encrypt("rand8", 0, 8, rm, re, rn, 1'b0, '0, '0);
        end

        // Plaintext equal to n.
        load_key(0, 32'd17, 128'd3233);
        plain = 128'd3233;
        pv8 = 1'b1;
        tick();
        pv8 = 1'b0;
        check("range/ready_drop", rdy8, 1'b0);
        tick();
`ifdef RSA_ENC_RANGE_CHECK_EN
        check("range/error_pulse", err8, 1'b1);
        check("range/no_valid", cv8, 1'b0);
        tick();
        check("range/error_clear", err8, 1'b0);
        check("range/ready_back", rdy8, 1'b1);
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cv8) pulses++;
        end
        check("range/no_cipher", pulses, 0);
`else
        check("range/error_tied", err8, 1'b0);
        cyc = 2;
        errs_seen = 0;
        while (!cv8 && cyc < 200) begin
            tick();
            cyc++;
            if (err8) errs_seen++;
        end
        check("range/latency", cyc, latency(32'd17, 8));
        check("range/error_never", errs_seen, 0);
        tick();
`endif

        // Reset in the middle of a squaring.
        encrypt("pre_rst", 0, 8, 128'd65, 32'd17, 128'd3233, 1'b0, '0, '0);
        plain = 128'd99;
        pv8 = 1'b1;
        tick();
        pv8 = 1'b0;
        repeat (20) tick();
        check("mid/busy_before", busy8, 1'b1);
        aresetn = 1'b0;
        #1;
        check("mid/cipher", word(0), 128'd0);
        check("mid/valid", cv8, 1'b0);
        check("mid/busy", busy8, 1'b0);
        check("mid/ready", rdy8, 1'b0);
        check("mid/error", err8, 1'b0);
        repeat (2) tick();
        aresetn = 1'b1;
        pulses = 0;
        ready_hi = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (cv8 || err8) pulses++;
            if (rdy8) ready_hi++;
        end
        check("mid/no_pulse", pulses, 0);
        check("mid/key_cleared", ready_hi, 0);
        load_key(0, 32'd17, 128'd3233);
        check("mid/reload", rdy8, 1'b1);
        encrypt("post_rst", 0, 8, 128'd42, 32'd17, 128'd3233, 1'b0, '0, '0);

        // WIDTH=32 with e=65537.
        load_key(1, 32'd65537, 128'hC34F_5A6B);
        check("w32/key_ok", rdy32, 1'b1);
        for (int i = 0; i < 3; i++) begin
            rm = {96'b0, $urandom} % 128'hC34F_5A6B;
            encrypt("w32", 1, 32, rm, 32'd65537, 128'hC34F_5A6B,
                    1'b0, '0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
